my_memory: RTL and testbench

- Single-port synchronous RAM: 4 words x 8 bits by default, parameterisable.
- One write-enable input, one shared address, registered read data output.
- Small scratchpad / register-file style storage block, used as a leaf in datapath designs and for teaching-level memory exercises.

---
 rtl/my_memory_pkg.sv | 7 +
 rtl/my_memory.sv | 34 +++
 tb/tb_my_memory.sv | 99 +++++++++
 3 files changed

// File: rtl/my_memory_pkg.sv
// my_memory_pkg: default geometry, word type and reset word shared by my_memory.
package my_memory_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    typedef logic [DATA_W-1:0] word_t;
    localparam word_t RST_WORD = '0;
endpackage

// File: rtl/my_memory.sv
// my_memory: single-port synchronous RAM with registered read, read-first by default.
// Define MEM_WRITE_THROUGH_EN for write-first (written data appears on data_out the same edge).
module my_memory
    import my_memory_pkg::*;
#(
    parameter int DATA_W = my_memory_pkg::DATA_W,
    parameter int ADDR_W = my_memory_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] dir,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] data_out_q, data_out_d;
`ifdef MEM_WRITE_THROUGH_EN
    assign data_out_d = we ? data_in : mem_q[dir];
`else
    assign data_out_d = mem_q[dir];
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= DATA_W'(RST_WORD);
            data_out_q <= DATA_W'(RST_WORD);
        end else begin
            if (we) mem_q[dir] <= data_in;
            data_out_q <= data_out_d;
        end
    end
    assign data_out = data_out_q;
endmodule

// File: tb/tb_my_memory.sv
// tb_my_memory: vector table plus randomized model run; expected words queued at drive, checked after the edge.
module tb_my_memory;
`ifdef MEM_WRITE_THROUGH_EN
    localparam bit WT = 1'b1;
`else
    localparam bit WT = 1'b0;
`endif
    typedef struct packed {
        logic       rst;
        logic       we;
        logic [1:0] dir;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       we = 1'b0;
    logic [1:0] dir = '0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    vec_t       vecs[$];
    logic [7:0] sb[$];
    logic [7:0] m [4];
    int         passed = 0;
    int         total = 0;
    always #2 clk = ~clk;
    my_memory dut (
        .clk(clk), .rst(rst), .we(we), .dir(dir), .data_in(data_in), .data_out(data_out)
    );
    function automatic void add(logic r, logic w, logic [1:0] d, logic [7:0] di, logic [7:0] e);
        vec_t v;
        v = '{rst: r, we: w, dir: d, din: di, exp: e};
        vecs.push_back(v);
    endfunction
    task automatic check(string name, logic [7:0] act, logic [7:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: data_out=%02h expected=%02h", name, act, req);
    endtask
    task automatic step(vec_t v, string name);
        @(negedge clk);
        rst = v.rst; we = v.we; dir = v.dir; data_in = v.din;
        sb.push_back(v.exp);
        @(posedge clk);
        #1;
        if (sb.size() == 0) check({name, "_empty"}, data_out, 8'hxx);
        else check(name, data_out, sb.pop_front());
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    initial begin
        logic [7:0] held;
        add(1, 1, 1, 8'hFF, 8'h00);
        add(1, 1, 1, 8'hFF, 8'h00);
        for (int a = 0; a < 4; a++) add(0, 0, 2'(a), 8'h00, 8'h00);
        for (int a = 0; a < 4; a++) add(0, 1, 2'(a), 8'(3 * (a + 1)), WT ? 8'(3 * (a + 1)) : 8'h00);
        for (int a = 0; a < 4; a++) add(0, 0, 2'(a), 8'(a), 8'(3 * (a + 1)));
        add(0, 1, 2, 8'd50, WT ? 8'd50 : 8'd9);
        add(0, 0, 2, 8'd0, 8'd50);
        add(1, 1, 3, 8'hAA, 8'h00);
        add(0, 0, 3, 8'h00, 8'h00);
        add(0, 0, 2, 8'h00, 8'h00);
        add(0, 1, 0, 8'h55, WT ? 8'h55 : 8'h00);
        add(0, 0, 1, 8'h00, 8'h00);
        add(0, 1, 1, 8'hA5, WT ? 8'hA5 : 8'h00);
        add(0, 0, 0, 8'h00, 8'h55);
        add(0, 0, 1, 8'h00, 8'hA5);
        for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));
        held = data_out;
        dir = 2'd0;
        we = 1'b1;
        data_in = 8'h3C;
        #1;
        check("hold_between_edges", data_out, 8'hA5);
        we = 1'b0;
        m = '{8'h55, 8'hA5, 8'h00, 8'h00};
        for (int i = 0; i < 12; i++) begin
            vec_t v;
            logic [1:0] a;
            logic [7:0] d;
            a = 2'($urandom_range(3));
            d = 8'($urandom);
            v = '{rst: 1'b0, we: 1'b1, dir: a, din: d, exp: WT ? d : m[a]};
            m[a] = d;
            step(v, $sformatf("rnd_wr%0d", i));
        end
        for (int a = 0; a < 4; a++) begin
            vec_t v;
            v = '{rst: 1'b0, we: 1'b0, dir: 2'(a), din: 8'hEE, exp: m[a]};
            step(v, $sformatf("rnd_rd%0d", a));
        end
        if (held !== 8'hA5) check("held_snapshot", held, 8'hA5);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
